// File: rtl/calc_cmd_driver.sv
// Command-side initiator for the accumulator calculator: splits byte operands into 3-bit en-framed steps.
// Latency: first calc_en one cycle after accept; steps*(HIGH_CYCLES+LOW_CYCLES) cycles per command, done in the last GAP cycle.
// Backpressure: cmd_ready only in IDLE; define CALC_DRV_CHUNK_EN to chunk ADD/SUB/SHL operands, otherwise one step of cmd_value[2:0].
module calc_cmd_driver #(
    parameter int HIGH_CYCLES = 1,
    parameter int LOW_CYCLES  = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_value,
    output logic       calc_en,
    output logic [2:0] calc_in,
    output logic [1:0] calc_op,
    output logic       busy,
    output logic       done
);
    localparam int CW = 16;
    localparam logic [CW-1:0] HI_LAST = CW'(HIGH_CYCLES - 1);
    localparam logic [CW-1:0] LO_LAST = CW'(LOW_CYCLES - 1);
    localparam logic [1:0]    OP_XOR  = 2'b10;

    typedef enum logic [1:0] {IDLE, ASSERT, GAP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          step_final;
    logic          gap_final;

`ifdef CALC_DRV_CHUNK_EN
    logic [7:0] remaining;
    logic [7:0] rem_after;

    function automatic logic [2:0] chunk(input logic [7:0] v);
        return (v > 8'd7) ? 3'd7 : v[2:0];
    endfunction

    // remaining already excludes the step in flight once we reach GAP
    assign rem_after  = remaining - {5'd0, calc_in};
    assign step_final = (rem_after == 8'd0);
    assign gap_final  = (remaining == 8'd0);
`else
    logic unused_value_hi;
    assign unused_value_hi = ^cmd_value[7:3];
    assign step_final      = 1'b1;
    assign gap_final       = 1'b1;
`endif

    assign busy      = (state != IDLE);
    assign cmd_ready = (state == IDLE) && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            calc_en <= 1'b0;
            calc_in <= 3'd0;
            calc_op <= 2'd0;
            done    <= 1'b0;
`ifdef CALC_DRV_CHUNK_EN
            remaining <= 8'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        state   <= ASSERT;
                        cnt     <= '0;
                        calc_en <= 1'b1;
                        calc_op <= cmd_op;
`ifdef CALC_DRV_CHUNK_EN
                        if (cmd_op == OP_XOR) begin
                            calc_in   <= cmd_value[2:0];
                            remaining <= {5'd0, cmd_value[2:0]};
                        end else begin
                            calc_in   <= chunk(cmd_value);
                            remaining <= cmd_value;
                        end
`else
                        calc_in <= cmd_value[2:0];
`endif
                    end
                end
                ASSERT: begin
                    if (cnt == HI_LAST) begin
                        state   <= GAP;
                        cnt     <= '0;
                        calc_en <= 1'b0;
                        done    <= step_final && (LO_LAST == '0);
`ifdef CALC_DRV_CHUNK_EN
                        remaining <= rem_after;
`endif
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                GAP: begin
                    if (cnt == LO_LAST) begin
                        cnt <= '0;
                        if (gap_final) begin
                            state <= IDLE;
                        end else begin
                            state   <= ASSERT;
                            calc_en <= 1'b1;
`ifdef CALC_DRV_CHUNK_EN
                            calc_in <= chunk(remaining);
`endif
                        end
                    end else begin
                        cnt  <= cnt + 16'd1;
                        done <= gap_final && (cnt + 16'd1 == LO_LAST);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_calc_cmd_driver.sv
// Bench for calc_cmd_driver: drives commands, models the calculator on calc_en rising edges.
module tb_calc_cmd_driver;
    localparam int H = 1;
    localparam int L = 1;
`ifdef CALC_DRV_CHUNK_EN
    localparam bit CHUNK = 1'b1;
`else
    localparam bit CHUNK = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_value = 8'd0;
    logic       calc_en;
    logic [2:0] calc_in;
    logic [1:0] calc_op;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_mis = 0;
    logic [7:0] cal_acc = 8'd0;

    calc_cmd_driver #(.HIGH_CYCLES(H), .LOW_CYCLES(L)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_value(cmd_value),
        .calc_en(calc_en), .calc_in(calc_in), .calc_op(calc_op),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] calc_step(input logic [7:0] acc, input logic [1:0] op, input logic [2:0] v);
        case (op)
            2'b00:   return acc + {5'd0, v};
            2'b01:   return acc - {5'd0, v};
            2'b10:   return acc ^ {5'd0, v};
            default: return acc << v;
        endcase
    endfunction

    // Whole-command reference: what the calculator should hold after the command.
    function automatic logic [7:0] ref_acc(input logic [7:0] acc, input logic [1:0] op, input logic [7:0] v);
        logic [7:0] eff;
        eff = (CHUNK && op != 2'b10) ? v : {5'd0, v[2:0]};
        case (op)
            2'b00:   return acc + eff;
            2'b01:   return acc - eff;
            2'b10:   return acc ^ eff;
            default: return (eff >= 8'd8) ? 8'd0 : (acc << eff);
        endcase
    endfunction

    function automatic int ref_steps(input logic [1:0] op, input logic [7:0] v);
        if (CHUNK && op != 2'b10) return (v == 8'd0) ? 1 : (int'(v) + 6) / 7;
        return 1;
    endfunction

    function automatic int ref_last(input logic [1:0] op, input logic [7:0] v);
        if (CHUNK && op != 2'b10) return int'(v) - 7 * (ref_steps(op, v) - 1);
        return int'(v[2:0]);
    endfunction

    task automatic run_cmd(input logic [1:0] op, input logic [7:0] v,
                           output int np, output int last, output int lat,
                           output int nd, output logic op_ok);
        logic prev;
        int   w;
        np = 0; last = -1; lat = -1; nd = 0; op_ok = 1'b1; prev = 1'b0; w = 0;
        @(negedge clock);
        while (!cmd_ready && w < 20) begin
            @(negedge clock);
            w++;
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_value = v;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_value = 8'($urandom);
        for (int d = 1; d <= 200 && nd == 0; d++) begin
            @(negedge clock);
            if (calc_en && !prev) begin
                np++;
                last = int'(calc_in);
                if (calc_op !== op) op_ok = 1'b0;
                cal_acc = calc_step(cal_acc, calc_op, calc_in);
            end
            prev = calc_en;
            if (done) begin
                nd++;
                lat = d;
            end
        end
        @(negedge clock);
        if (done) nd++;
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] val;
        logic [7:0] acc0;
        int         steps;
        int         last_in;
        logic [7:0] acc;
    } vec_t;

    vec_t vt[8];

    initial begin
        int np, last, lat, nd, target, rdy_at;
        logic op_ok, prev;
        logic [1:0] rop;
        logic [7:0] rv, exp_acc;
        int rises[$];

        vt[0] = '{2'b00, 8'd5,   8'h00, 1,              5,              8'd5};
        vt[1] = '{2'b00, 8'd20,  8'h00, CHUNK ? 3 : 1,  CHUNK ? 6 : 4,  CHUNK ? 8'd20 : 8'd4};
        vt[2] = '{2'b11, 8'd9,   8'h01, CHUNK ? 2 : 1,  CHUNK ? 2 : 1,  CHUNK ? 8'h00 : 8'h02};
        vt[3] = '{2'b10, 8'hFD,  8'h00, 1,              5,              8'h05};
        vt[4] = '{2'b00, 8'd0,   8'h33, 1,              0,              8'h33};
        vt[5] = '{2'b01, 8'd3,   8'd10, 1,              3,              8'd7};
        vt[6] = '{2'b00, 8'd255, 8'h00, CHUNK ? 37 : 1, CHUNK ? 3 : 7,  CHUNK ? 8'd255 : 8'd7};
        vt[7] = '{2'b01, 8'd14,  8'h00, CHUNK ? 2 : 1,  CHUNK ? 7 : 6,  CHUNK ? 8'hF2 : 8'hFA};

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_calc_en", 32'(calc_en), 0);
        check("rst_calc_in", 32'(calc_in), 0);
        check("rst_calc_op", 32'(calc_op), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_cmd_ready", 32'(cmd_ready), 1);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            cal_acc = vt[i].acc0;
            run_cmd(vt[i].op, vt[i].val, np, last, lat, nd, op_ok);
            check($sformatf("vec%0d_pulses", i), 32'(np), 32'(vt[i].steps));
            check($sformatf("vec%0d_last_in", i), 32'(last), 32'(vt[i].last_in));
            check($sformatf("vec%0d_done_lat", i), 32'(lat), 32'(vt[i].steps * (H + L)));
            check($sformatf("vec%0d_done_cnt", i), 32'(nd), 1);
            check($sformatf("vec%0d_op_const", i), 32'(op_ok), 1);
            check($sformatf("vec%0d_acc", i), 32'(cal_acc), 32'(vt[i].acc));
            check($sformatf("vec%0d_ready_after", i), 32'(cmd_ready), 1);
        end

        // Randomized commands against the whole-command reference
        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            rv  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 255));
            exp_acc = ref_acc(cal_acc, rop, rv);
            run_cmd(rop, rv, np, last, lat, nd, op_ok);
            check($sformatf("rnd%0d_pulses op=%0d v=%0d", i, rop, rv), 32'(np), 32'(ref_steps(rop, rv)));
            check($sformatf("rnd%0d_last_in op=%0d v=%0d", i, rop, rv), 32'(last), 32'(ref_last(rop, rv)));
            check($sformatf("rnd%0d_done_lat", i), 32'(lat), 32'(ref_steps(rop, rv) * (H + L)));
            check($sformatf("rnd%0d_acc op=%0d v=%0d", i, rop, rv), 32'(cal_acc), 32'(exp_acc));
        end

        // Reset mid-command
        @(negedge clock);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_value = 8'd100;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        target = CHUNK ? 3 : 1;
        np = 0; nd = 0; prev = 1'b0;
        for (int d = 0; d < 100 && np < target; d++) begin
            @(negedge clock);
            if (calc_en && !prev) np++;
            prev = calc_en;
            if (done) nd++;
        end
        check("abort_pulses_seen", 32'(np), 32'(target));
        reset = 1'b1;
        @(negedge clock);
        check("abort_calc_en", 32'(calc_en), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_calc_in", 32'(calc_in), 0);
        check("abort_done", 32'(done), 0);
        check("abort_ready_in_reset", 32'(cmd_ready), 0);
        reset = 1'b0;
        @(negedge clock);
        check("abort_ready_after_release", 32'(cmd_ready), 1);
        repeat (5) begin
            @(negedge clock);
            if (done) nd++;
        end
        check("abort_no_done", 32'(nd), 0);

        // Back-to-back with cmd_valid held high
        cal_acc = 8'd10;
        @(negedge clock);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_value = 8'd3;
        @(posedge clock);
        #1;
        nd = 0; rdy_at = -1; prev = 1'b0;
        for (int d = 1; d <= 40 && nd < 2; d++) begin
            @(negedge clock);
            if (calc_en && !prev) begin
                rises.push_back(d);
                cal_acc = calc_step(cal_acc, calc_op, calc_in);
            end
            prev = calc_en;
            if (cmd_ready && rdy_at < 0) rdy_at = d;
            if (done) nd++;
        end
        cmd_valid = 1'b0;
        check("b2b_pulses", 32'(rises.size()), 2);
        check("b2b_ready_cycle", 32'(rdy_at), 32'(H + L + 1));
        check("b2b_rise_spacing", 32'(rises.size() >= 2 ? rises[1] - rises[0] : -1), 32'(H + L + 1));
        check("b2b_done_cnt", 32'(nd), 2);
        check("b2b_acc", 32'(cal_acc), 4);
        repeat (3) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
